// File: rtl/hash_row_coalescer_if.sv
// rtl/hash_row_coalescer_if.sv - beat input and row output bundle of the hash row coalescer
// slave is the coalescer side, master the producer/consumer side.
interface hash_row_coalescer_if #(
  parameter int LANES  = 16,
  parameter int ADDR_W = 32,
  parameter int MLEN_W = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [ADDR_W-1:0]         in_head_addr;
  logic [LANES-1:0]          in_lane_mask;
  logic [LANES-1:0]          in_hist_valid;
  logic [LANES*ADDR_W-1:0]   in_hist_addr;
  logic [LANES*MLEN_W-1:0]   in_mlen;
  logic [LANES-1:0]          in_can_ext;
  logic [LANES*8-1:0]        in_data;
  logic                      in_delim;

  logic                      out_valid;
  logic                      out_ready;
  logic [ADDR_W-1:0]         out_head_addr;
  logic [LANES-1:0]          out_lane_mask;
  logic [LANES-1:0]          out_hist_valid;
  logic [LANES*ADDR_W-1:0]   out_hist_addr;
  logic [LANES*MLEN_W-1:0]   out_mlen;
  logic [LANES-1:0]          out_can_ext;
  logic [LANES*8-1:0]        out_data;
  logic                      out_delim;

  modport slave (
    input  in_valid, in_head_addr, in_lane_mask, in_hist_valid, in_hist_addr,
           in_mlen, in_can_ext, in_data, in_delim, out_ready,
    output in_ready, out_valid, out_head_addr, out_lane_mask, out_hist_valid,
           out_hist_addr, out_mlen, out_can_ext, out_data, out_delim
  );

  modport master (
    output in_valid, in_head_addr, in_lane_mask, in_hist_valid, in_hist_addr,
           in_mlen, in_can_ext, in_data, in_delim, out_ready,
    input  in_ready, out_valid, out_head_addr, out_lane_mask, out_hist_valid,
           out_hist_addr, out_mlen, out_can_ext, out_data, out_delim
  );
endinterface

// File: rtl/hash_row_coalescer.sv
// rtl/hash_row_coalescer.sv - merges sparse per-lane hash beats into dense registered rows
// Optional idle-timeout flush of partial rows: define HASH_ROW_COALESCER_TIMEOUT_EN.
module hash_row_coalescer #(
  parameter int LANES  = 16,
  parameter int ADDR_W = 32,
  parameter int MLEN_W = 5,
  parameter int CNT_W  = $clog2(LANES) + 1,
  parameter int TO_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   cfg_max_beats,
  input  logic [TO_W-1:0]    cfg_timeout,
  hash_row_coalescer_if.slave bus
);
  localparam logic [1:0] ST_RECV  = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0]       head;
    logic [LANES-1:0]        mask;
    logic [LANES-1:0]        hv;
    logic [LANES*ADDR_W-1:0] ha;
    logic [LANES*MLEN_W-1:0] mlen;
    logic [LANES-1:0]        ce;
    logic [LANES*8-1:0]      data;
    logic                    delim;
  } row_t;

  logic [1:0]       state_q, state_d;
  row_t             acc_q, acc_d, comb, ld_row;
  row_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, cnt_max;
  logic             in_recv, collision, to_fire, in_ready, beat_acc, acc_flush;
  logic             out_free, trigger, ld_en, clr;

  assign in_recv   = (state_q == ST_RECV);
  assign out_free  = !out_valid_q || bus.out_ready;
  assign collision = bus.in_valid && in_recv && |(acc_q.mask & bus.in_lane_mask);
  assign in_ready  = rst_n && in_recv && !collision && !to_fire;
  assign beat_acc  = bus.in_valid && in_ready;
  assign acc_flush = collision || to_fire;
  assign cnt_max   = (cfg_max_beats == '0) ? CNT_W'(1) : cfg_max_beats;

`ifdef HASH_ROW_COALESCER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Fires on the cfg_timeout-th consecutive idle cycle of a non-empty accumulator.
  assign to_fire  = in_recv && (cfg_timeout != '0) && |acc_q.mask &&
                    (({1'b0, to_cnt_q} + (TO_W+1)'(1)) >= {1'b0, cfg_timeout});
  assign to_cnt_d = (in_recv && |acc_q.mask && !beat_acc && !ld_en)
                  ? ((&to_cnt_q) ? to_cnt_q : to_cnt_q + TO_W'(1)) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign to_fire = 1'b0;
`endif

  // Accumulator merged with the current beat; unmasked lanes contribute nothing.
  always_comb begin
    comb       = acc_q;
    comb.head  = bus.in_head_addr;
    comb.data  = bus.in_data;
    comb.delim = bus.in_delim;
    comb.mask  = acc_q.mask | bus.in_lane_mask;
    comb.hv    = acc_q.hv | (bus.in_lane_mask & bus.in_hist_valid);
    comb.ce    = acc_q.ce | (bus.in_lane_mask & bus.in_can_ext);
    for (int i = 0; i < LANES; i++) begin
      comb.ha[i*ADDR_W +: ADDR_W] = acc_q.ha[i*ADDR_W +: ADDR_W] |
          (bus.in_hist_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{bus.in_lane_mask[i]}});
      comb.mlen[i*MLEN_W +: MLEN_W] = acc_q.mlen[i*MLEN_W +: MLEN_W] |
          (bus.in_mlen[i*MLEN_W +: MLEN_W] & {MLEN_W{bus.in_lane_mask[i]}});
    end
  end

  assign trigger = (({1'b0, beat_cnt_q} + (CNT_W+1)'(1)) >= {1'b0, cnt_max}) ||
                   (&comb.mask) || bus.in_delim;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    ld_en       = 1'b0;
    ld_row      = acc_q;
    clr         = 1'b0;
    case (state_q)
      ST_RECV: begin
        if (acc_flush) begin
          if (out_free) begin
            ld_en = 1'b1;
            clr   = 1'b1;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if (beat_acc) begin
          if (trigger && out_free) begin
            ld_en  = 1'b1;
            ld_row = comb;
            clr    = 1'b1;
          end else if (trigger) begin
            acc_d   = comb;
            state_d = ST_FLUSH;
          end else begin
            acc_d      = comb;
            beat_cnt_d = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          ld_en   = 1'b1;
          clr     = 1'b1;
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_RECV;
    endcase
    if (clr) begin
      acc_d      = '0;
      beat_cnt_d = '0;
    end
    // Rows with no history hit are dropped unless they carry the delimiter.
    if (ld_en && (|ld_row.hv || ld_row.delim)) begin
      out_d       = ld_row;
      out_d.mask  = ld_row.hv;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RECV;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_head_addr  = out_q.head;
  assign bus.out_lane_mask  = out_q.mask;
  assign bus.out_hist_valid = out_q.hv;
  assign bus.out_hist_addr  = out_q.ha;
  assign bus.out_mlen       = out_q.mlen;
  assign bus.out_can_ext    = out_q.ce;
  assign bus.out_data       = out_q.data;
  assign bus.out_delim      = out_q.delim;
endmodule

// File: tb/tb_hash_row_coalescer.sv
// tb/tb_hash_row_coalescer.sv - directed bench for hash_row_coalescer with a row-level model
// Timeout checks follow HASH_ROW_COALESCER_TIMEOUT_EN.
module tb_hash_row_coalescer;
  localparam int LANES = 16, ADDR_W = 32, MLEN_W = 5, CNT_W = 5, TO_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] cfg_max_beats;
  logic [TO_W-1:0]  cfg_timeout;
  int               total = 0;
  int               bad = 0;

  hash_row_coalescer_if #(.LANES(LANES), .ADDR_W(ADDR_W), .MLEN_W(MLEN_W)) bus ();

  hash_row_coalescer #(.LANES(LANES), .ADDR_W(ADDR_W), .MLEN_W(MLEN_W),
                       .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_max_beats(cfg_max_beats),
    .cfg_timeout(cfg_timeout), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]       head;
    logic [LANES-1:0]        mask;
    logic [LANES*ADDR_W-1:0] ha;
    logic [LANES*MLEN_W-1:0] mlen;
    logic [LANES-1:0]        ce;
    logic [LANES*8-1:0]      data;
    logic                    delim;
  } row_t;

  row_t             exp_q[$];
  row_t             m_acc;
  logic [LANES-1:0] m_occ;
  int               m_cnt;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    m_acc.head = '0; m_acc.mask = '0; m_acc.ha = '0; m_acc.mlen = '0;
    m_acc.ce = '0; m_acc.data = '0; m_acc.delim = 1'b0;
    m_occ = '0;
    m_cnt = 0;
  endtask

  task automatic model_flush();
    if (m_acc.mask != '0 || m_acc.delim) exp_q.push_back(m_acc);
    model_clear();
  endtask

  // Row-level rules: a beat hitting an occupied lane first closes the current row.
  task automatic model_accept();
    int lim;
    lim = (cfg_max_beats == '0) ? 1 : int'(cfg_max_beats);
    if ((m_occ & bus.in_lane_mask) != '0) model_flush();
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_lane_mask[i]) begin
        m_acc.mask[i] = bus.in_hist_valid[i];
        m_acc.ha[i*ADDR_W +: ADDR_W] = bus.in_hist_addr[i*ADDR_W +: ADDR_W];
        m_acc.mlen[i*MLEN_W +: MLEN_W] = bus.in_mlen[i*MLEN_W +: MLEN_W];
        m_acc.ce[i] = bus.in_can_ext[i];
      end
    end
    m_occ = m_occ | bus.in_lane_mask;
    m_cnt++;
    m_acc.head  = bus.in_head_addr;
    m_acc.data  = bus.in_data;
    m_acc.delim = bus.in_delim;
    if (m_cnt >= lim || (&m_occ) || bus.in_delim) model_flush();
  endtask

  task automatic send_beat(input logic [LANES-1:0] m, input logic [LANES-1:0] hv,
                           input int seed, input logic dl, output int waits);
    bit done;
    bus.in_valid      = 1'b1;
    bus.in_lane_mask  = m;
    bus.in_hist_valid = hv;
    bus.in_head_addr  = ADDR_W'(seed * 256);
    bus.in_can_ext    = 16'h5A5A ^ {LANES{seed[0]}};
    bus.in_delim      = dl;
    for (int i = 0; i < LANES; i++) begin
      bus.in_hist_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(32'hA000_0000 | (seed << 8) | i);
      bus.in_mlen[i*MLEN_W +: MLEN_W]      = MLEN_W'(seed * 3 + i + 1);
      bus.in_data[i*8 +: 8]                = 8'(seed * 16 + i);
    end
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept();
        done = 1'b1;
      end else if (waits >= 50) begin
        chk("beat_accept_timeout", 1'b0, 1'b1);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Every output handshake is checked against the model; stalled rows must hold.
  logic         stall_prev = 1'b0;
  logic [176:0] held;
  initial begin
    row_t r;
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (stall_prev)
          chk("hold_row", {bus.out_head_addr, bus.out_lane_mask, bus.out_delim, bus.out_data}, held);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_row", bus.out_lane_mask, 16'hDEAD);
          end else begin
            r = exp_q.pop_front();
            chk("row_lane_mask", bus.out_lane_mask, r.mask);
            chk("row_hist_valid", bus.out_hist_valid, r.mask);
            chk("row_head", bus.out_head_addr, r.head);
            chk("row_hist_addr", bus.out_hist_addr, r.ha);
            chk("row_mlen", bus.out_mlen, r.mlen);
            chk("row_can_ext", bus.out_can_ext, r.ce);
            chk("row_data", bus.out_data, r.data);
            chk("row_delim", bus.out_delim, r.delim);
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held = {bus.out_head_addr, bus.out_lane_mask, bus.out_delim, bus.out_data};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    int w, k;
    bit seen;
    model_clear();
    bus.in_valid = 1'b0; bus.in_head_addr = '0; bus.in_lane_mask = '0;
    bus.in_hist_valid = '0; bus.in_hist_addr = '0; bus.in_mlen = '0;
    bus.in_can_ext = '0; bus.in_data = '0; bus.in_delim = 1'b0;
    bus.out_ready = 1'b1;
    cfg_max_beats = 5'd4;
    cfg_timeout   = 8'd10;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_mask", bus.out_lane_mask, 16'h0);
    chk("rst_out_head", bus.out_head_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Full-row flush: second beat completes all lanes.
    send_beat(16'h00FF, 16'h00FF, 1, 1'b0, w);
    send_beat(16'hFF00, 16'hF0F0, 2, 1'b0, w);
    chk("full_valid", bus.out_valid, 1'b1);
    chk("full_mask", bus.out_lane_mask, 16'hF0FF);

    // Beat-count flush after three beats.
    cfg_max_beats = 5'd3;
    send_beat(16'h0001, 16'hFFFF, 3, 1'b0, w);
    send_beat(16'h0002, 16'hFFFF, 4, 1'b0, w);
    send_beat(16'h0004, 16'hFFFF, 5, 1'b0, w);
    chk("cnt_valid", bus.out_valid, 1'b1);
    chk("cnt_mask", bus.out_lane_mask, 16'h0007);
    chk("cnt_head", bus.out_head_addr, 32'h0000_0500);
    @(posedge clk); #1;

    // Backpressure: second row waits in FLUSH while the first is stalled.
    cfg_max_beats = 5'd1;
    bus.out_ready = 1'b0;
    send_beat(16'h000F, 16'h000F, 6, 1'b0, w);
    send_beat(16'h0030, 16'h0030, 7, 1'b0, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 1'b0);
      chk("bp_stall_mask", bus.out_lane_mask, 16'h000F);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("bp_resume_in_ready", bus.in_ready, 1'b1);
    chk("bp_second_mask", bus.out_lane_mask, 16'h0030);
    @(posedge clk); #1;

    // Collision: lane 1 already occupied, beat waits one cycle.
    cfg_max_beats = 5'd4;
    send_beat(16'h0003, 16'h0003, 8, 1'b0, w);
    send_beat(16'h0002, 16'h0002, 9, 1'b0, w);
    chk("coll_waits", w, 1);
    send_beat(16'h0000, 16'h0000, 10, 1'b1, w);
    chk("coll_tail_mask", bus.out_lane_mask, 16'h0002);
    chk("coll_tail_delim", bus.out_delim, 1'b1);

    // Delimiter on an empty accumulator.
    send_beat(16'h0000, 16'h0000, 11, 1'b1, w);
    chk("delim_valid", bus.out_valid, 1'b1);
    chk("delim_mask", bus.out_lane_mask, 16'h0000);
    chk("delim_flag", bus.out_delim, 1'b1);

    // Row without history hits and without delimiter is dropped.
    cfg_max_beats = 5'd1;
    send_beat(16'h0100, 16'h0000, 12, 1'b0, w);
    chk("drop_valid", bus.out_valid, 1'b0);

    // One row per cycle when every beat flushes.
    for (int b = 0; b < 4; b++) begin
      send_beat(LANES'(1) << b, LANES'(1) << b, 20 + b, 1'b0, w);
      chk("thru_waits", w, 0);
      chk("thru_valid", bus.out_valid, 1'b1);
    end
    @(posedge clk); #1;

    // Idle timeout on a partial row.
    cfg_max_beats = 5'd4;
    send_beat(16'h0010, 16'h0010, 13, 1'b0, w);
`ifdef HASH_ROW_COALESCER_TIMEOUT_EN
    model_flush();
    k = 1;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_latency", k, 11);
    chk("timeout_mask", bus.out_lane_mask, 16'h0010);
`else
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no_timeout_row", seen, 1'b0);
    send_beat(16'h0000, 16'h0000, 14, 1'b1, w);
    chk("late_flush_mask", bus.out_lane_mask, 16'h0010);
`endif

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash_row_coalescer.md
# hash_row_coalescer

Parametrised row coalescer between the hash-table lookup stage and the match PEs. It merges sparse per-lane hash results, arriving over several beats, into one dense row of `LANES` positions and emits that row through a registered valid/ready output. The block generalises the fixed-width row synchroniser in four ways:
- lane count is a parameter;
- lane collisions are detected and handled;
- a delimiter beat forces a flush;
- an optional idle timeout flushes partially filled rows.

## Interface
Parameters:
- `LANES`, default 16: lanes per row; must be a power of two, ≥2.
- `ADDR_W`, default 32: history/head address width.
- `MLEN_W`, default 5: meta match length width per lane.
- `CNT_W`, default $clog2(LANES)+1: beat-counter and `cfg_max_beats` width (derived).
- `TO_W`, default 8: timeout counter width. Only used with the timeout feature compiled in.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `cfg_max_beats`, in, `CNT_W`: maximum beats merged per row; 0 is treated as 1.
- `cfg_timeout`, in, `TO_W`: idle cycles before a partial row is flushed; 0 disables the timeout.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: input beat accepted.
- `in_head_addr`, in, `ADDR_W`: address of lane 0.
- `in_lane_mask`, in, `LANES`: lanes carried by this beat.
- `in_hist_valid`, in, `LANES`: per-lane history hit.
- `in_hist_addr`, in, `LANES*ADDR_W`: per-lane history address.
- `in_mlen`, in, `LANES*MLEN_W`: per-lane meta match length.
- `in_can_ext`, in, `LANES`: per-lane meta match can-extend flag.
- `in_data`, in, `LANES*8`: literal bytes.
- `in_delim`, in, 1: last beat of a block.
- `out_valid`, out, 1: output row valid.
- `out_ready`, in, 1: output row accepted.
- Output row fields: `out_head_addr`, `out_lane_mask`, `out_hist_valid`, `out_hist_addr`, `out_mlen`, `out_can_ext`, `out_data`, `out_delim`, with widths matching the corresponding inputs.

## Operation
Accumulator state:
- `acc_mask`, `acc_hist_valid`, `acc_hist_addr`, `acc_mlen`, `acc_can_ext`, `beat_cnt`.
- `head_addr`, `data` and `delim` are taken from the most recent accepted beat.

Merging:
- The merge is per lane: each input field is ANDed with `in_lane_mask[i]`, then ORed into the accumulator.
- `hist_valid` is merged as `in_lane_mask & in_hist_valid`.
- `combined_*` denotes the accumulator merged with the current beat.

Collision:
- A collision exists when `|(acc_mask & in_lane_mask)` with `in_valid` high in RECV.
- The input is not accepted that cycle (`in_ready`=0). The accumulator alone is flushed to the output, and the beat is accepted on a later cycle into the empty accumulator.
- Data is never ORed over an occupied lane.

Flush triggers on an accepted beat (no collision):
- `beat_cnt+1 >= max(cfg_max_beats,1)`, or
- `&combined_mask`, or
- `in_delim`.

States, one-hot:
- **RECV**:
  - `in_ready`=1 unless there is a collision, or a pending timeout flush is blocked.
  - On an accepted beat with no flush trigger: merge into the accumulator and increment `beat_cnt`.
  - On a flush trigger, if the output register is free (empty, or `out_ready` high this cycle): load the combined row into the output register, clear the accumulator, set `beat_cnt`=0.
  - On a flush trigger when the output register is not free: store the combined row in the accumulator and go to FLUSH.
- **FLUSH**:
  - `in_ready`=0.
  - When the output register is free, load the accumulator into it, clear the accumulator and return to RECV.

Output register behaviour:
- `out_lane_mask` equals the flushed `hist_valid`. Lanes without a hit are reported as invalid.
- A flushed row whose mask is all-zero is still emitted if `delim`=1, so the delimiter is propagated.
- If the mask is all-zero and `delim`=0, the row is dropped silently.

## Timing
Reset values:
- State = RECV; accumulator, `beat_cnt` and timeout counter all 0.
- `out_valid`=0; all `out_*` fields are 0.
- `in_ready`=0 during reset, 1 in the first cycle after reset.

Latency: the flush-triggering beat appears on `out_*` with `out_valid`=1 exactly one cycle after its handshake.

Output handshake: `out_*` hold stable while `out_valid` is high and `out_ready` is low. Throughput is one row per cycle when every beat triggers a flush and `out_ready`=1.

Simultaneous events: a collision and a timeout in the same cycle produce a single flush. `rst_n` low mid-FLUSH discards the pending row with no output.

`beat_cnt` saturates at `2^CNT_W-1` and does not wrap.

## Configuration
Macro: `HASH_ROW_COALESCER_TIMEOUT_EN`.

When defined:
- The timeout counter increments each cycle in RECV while `acc_mask` is non-zero and no beat is accepted.
- It resets to 0 on any accepted beat or any flush.
- When it reaches `cfg_timeout` (with `cfg_timeout` ≠ 0), the accumulator is flushed as if by a trigger, and `in_ready` is 0 in that cycle.

When undefined: there is no timeout logic, `cfg_timeout` is ignored, and partial rows wait for a trigger.

## Test plan
- **Full-row flush:** `LANES`=16, `cfg_max_beats`=4, beats with masks 0x00FF then 0xFF00, `out_ready`=1 → one row, `out_lane_mask`=`hist_valid` merge, emitted 1 cycle after the second beat.
- **Beat-count flush:** `cfg_max_beats`=3, three beats with masks 0x0001, 0x0002, 0x0004 → one row with mask 0x0007, `head_addr` from beat 3.
- **Backpressure:** `out_ready`=0 at a flush trigger → FLUSH entered, `in_ready`=0 for 5 cycles. Release `out_ready` → row emitted unchanged, RECV resumes.
- **Collision:** accumulator mask 0x0003, beat mask 0x0002 → `in_ready`=0, old row emitted with mask 0x0003, beat accepted the next cycle into a fresh accumulator.
- **Delimiter:** beat with mask 0x0000 and `in_delim`=1 on an empty accumulator → row emitted with mask 0 and `out_delim`=1.
- **Timeout** (macro defined, `cfg_timeout`=10): one beat with mask 0x0010, then idle → partial row emitted 11 cycles after the beat. With the macro undefined, no output appears.
